bomb_countdown_timer: RTL and testbench



---
 rtl/bomb_countdown_timer_pkg.sv | 21 ++
 rtl/bomb_countdown_timer_bcd_digit_down.sv | 27 ++
 rtl/bomb_countdown_timer.sv | 169 ++++++++++++++++
 tb/tb_bomb_countdown_timer.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/bomb_countdown_timer_pkg.sv
// Shared types and constants for the bomb countdown timer: state encoding,
// BCD limits and default timing parameters.
package bomb_countdown_timer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_PAUSED  = 2'd2,
        ST_EXPIRED = 2'd3
    } state_t;

    localparam logic [3:0] BCD_MAX            = 4'd9;
    localparam int         DEFAULT_TICK_DIV   = 50000000;
    localparam int         DEFAULT_WARN_LEVEL = 10;

    // Out-of-range load digits saturate to the largest legal BCD digit.
    function automatic logic [3:0] bcd_clamp(input logic [3:0] value);
        return (value > BCD_MAX) ? BCD_MAX : value;
    endfunction

endpackage

// File: rtl/bomb_countdown_timer_bcd_digit_down.sv
// Combinational single BCD digit decrement with borrow chaining and a
// zero flag on the resulting digit.
module bcd_digit_down
    import bomb_countdown_timer_pkg::*;
(
    input  logic [3:0] digit,
    input  logic       borrow_in,
    output logic [3:0] result,
    output logic       borrow_out,
    output logic       is_zero
);

    logic digit_is_zero;

    assign digit_is_zero = (digit == 4'd0);
    assign borrow_out    = borrow_in && digit_is_zero;

    always_comb begin
        result = digit;
        if (borrow_in) begin
            result = digit_is_zero ? BCD_MAX : (digit - 4'd1);
        end
    end

    assign is_zero = (result == 4'd0);

endmodule

// File: rtl/bomb_countdown_timer.sv
// Three-digit BCD countdown timer with start/pause, a 10 s penalty, a
// low-time warning and a sticky expiry (detonation) flag.
module bomb_countdown_timer
    import bomb_countdown_timer_pkg::*;
#(
    parameter int TICK_DIV   = DEFAULT_TICK_DIV,
    parameter int WARN_LEVEL = DEFAULT_WARN_LEVEL
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic [3:0] value_three,
    input  logic [3:0] value_two,
    input  logic [3:0] value_one,
    input  logic       start,
    input  logic       pause,
    input  logic       penalty,
    output logic [3:0] digit_three,
    output logic [3:0] digit_two,
    output logic [3:0] digit_one,
    output logic       running,
    output logic       tick,
    output logic       warning,
    output logic       expired
);

    localparam int                 PRESC_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICK_DIV - 1);
    localparam logic [9:0]         WARN_VAL   = 10'(WARN_LEVEL);

    // Digit index 0 = units, 1 = tens, 2 = hundreds.
    state_t             state_reg, state_next;
    logic [PRESC_W-1:0] presc_reg, presc_next;
    logic [3:0]         digit_reg  [3];
    logic [3:0]         digit_next [3];
    logic               tick_reg, tick_next;

    logic               at_wrap;
    logic               in_run;
    logic               pen_ok;
    logic               halt;
    logic               count_en;
    logic               dec;
    logic               underflow;
    logic               result_zero;
    logic               digits_zero;
    logic [9:0]         value;

    logic [3:0]         tick_digit [3];
    logic [3:0]         tick_borrow;
    logic [2:0]         tick_zero;
    logic [3:0]         pen_digit  [3];
    logic [3:1]         pen_borrow;
    logic [2:1]         pen_zero;

    assign at_wrap  = (presc_reg == PRESC_LAST);
    assign in_run   = (state_reg == ST_RUN);
    assign pen_ok   = !load && penalty && (state_reg == ST_RUN || state_reg == ST_PAUSED);
    assign halt     = in_run && pause && !pen_ok;
    assign count_en = in_run && !load && !halt;
    assign dec      = count_en && at_wrap;

    // One-second decrement chain: units -> tens -> hundreds.
    assign tick_borrow[0] = dec;
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_tick
            bcd_digit_down u_tick_digit (
                .digit      (digit_reg[gi]),
                .borrow_in  (tick_borrow[gi]),
                .result     (tick_digit[gi]),
                .borrow_out (tick_borrow[gi+1]),
                .is_zero    (tick_zero[gi])
            );
        end
    endgenerate

    // Penalty chain takes 10 off the tick result, so a coincident penalty
    // and decrement subtract 11 in a single edge.
    assign pen_borrow[1] = pen_ok;
    assign pen_digit[0]  = tick_digit[0];
    generate
        for (genvar gi = 1; gi < 3; gi++) begin : g_pen
            bcd_digit_down u_pen_digit (
                .digit      (tick_digit[gi]),
                .borrow_in  (pen_borrow[gi]),
                .result     (pen_digit[gi]),
                .borrow_out (pen_borrow[gi+1]),
                .is_zero    (pen_zero[gi])
            );
        end
    endgenerate

    assign underflow   = tick_borrow[3] | pen_borrow[3];
    assign result_zero = tick_zero[0] & pen_zero[1] & pen_zero[2];
    // Start is only acted on outside RUN, where dec is low and the tick chain
    // passes the registered digits through unchanged.
    assign digits_zero = &tick_zero;

    always_comb begin
        state_next = state_reg;
        presc_next = presc_reg;
        tick_next  = 1'b0;
        for (int i = 0; i < 3; i++) begin
            digit_next[i] = digit_reg[i];
        end

        if (load) begin
            digit_next[0] = bcd_clamp(value_one);
            digit_next[1] = bcd_clamp(value_two);
            digit_next[2] = bcd_clamp(value_three);
            presc_next    = '0;
            state_next    = ST_IDLE;
        end else begin
            if (count_en) begin
                presc_next = at_wrap ? '0 : presc_reg + 1'b1;
            end
            if (dec || pen_ok) begin
                tick_next = dec;
                if (underflow || result_zero) begin
                    for (int i = 0; i < 3; i++) begin
                        digit_next[i] = 4'd0;
                    end
                    state_next = ST_EXPIRED;
                end else begin
                    for (int i = 0; i < 3; i++) begin
                        digit_next[i] = pen_digit[i];
                    end
                end
            end else begin
                case (state_reg)
                    ST_IDLE:   if (start) state_next = digits_zero ? ST_EXPIRED : ST_RUN;
                    ST_PAUSED: if (start) state_next = ST_RUN;
                    ST_RUN:    if (pause) state_next = ST_PAUSED;
                    default:   ;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= ST_IDLE;
            presc_reg <= '0;
            tick_reg  <= 1'b0;
            for (int i = 0; i < 3; i++) begin
                digit_reg[i] <= 4'd0;
            end
        end else begin
            state_reg <= state_next;
            presc_reg <= presc_next;
            tick_reg  <= tick_next;
            for (int i = 0; i < 3; i++) begin
                digit_reg[i] <= digit_next[i];
            end
        end
    end

    assign value = 10'(digit_reg[2]) * 10'd100 + 10'(digit_reg[1]) * 10'd10 + 10'(digit_reg[0]);

    assign digit_one   = digit_reg[0];
    assign digit_two   = digit_reg[1];
    assign digit_three = digit_reg[2];
    assign running     = in_run;
    assign expired     = (state_reg == ST_EXPIRED);
    assign tick        = tick_reg;
    assign warning     = (state_reg == ST_RUN || state_reg == ST_PAUSED)
                         && (value != 10'd0) && (value <= WARN_VAL);

endmodule

// File: tb/tb_bomb_countdown_timer.sv
// Directed bench for bomb_countdown_timer: a seconds-level model checked every
// cycle plus literal expectations at the key points of each scenario.
module tb_bomb_countdown_timer;

    localparam int TD = 4;
    localparam int WL = 10;
    localparam int M_IDLE = 0, M_RUN = 1, M_PAUSED = 2, M_EXPIRED = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       load = 1'b0;
    logic [3:0] value_three = 4'd0, value_two = 4'd0, value_one = 4'd0;
    logic       start = 1'b0, pause = 1'b0, penalty = 1'b0;
    logic [3:0] digit_three, digit_two, digit_one;
    logic       running, tick, warning, expired;

    int n_checks = 0;
    int n_fail   = 0;
    bit check_en = 1'b0;

    // Model state: remaining seconds as a plain integer.
    int m_rem = 0, m_st = M_IDLE, m_presc = 0;
    bit m_tick = 1'b0;

    bomb_countdown_timer #(.TICK_DIV(TD), .WARN_LEVEL(WL)) dut (
        .clk(clk), .reset(reset), .load(load),
        .value_three(value_three), .value_two(value_two), .value_one(value_one),
        .start(start), .pause(pause), .penalty(penalty),
        .digit_three(digit_three), .digit_two(digit_two), .digit_one(digit_one),
        .running(running), .tick(tick), .warning(warning), .expired(expired)
    );

    always #5 clk = ~clk;

    function automatic int clampd(input logic [3:0] v);
        return (v > 4'd9) ? 9 : int'(v);
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        int st_old;
        int sub;
        bit pen_ok;
        st_old = m_st;
        sub    = 0;
        m_tick = 1'b0;
        if (reset) begin
            m_st = M_IDLE; m_rem = 0; m_presc = 0;
        end else if (load) begin
            m_rem   = clampd(value_three) * 100 + clampd(value_two) * 10 + clampd(value_one);
            m_st    = M_IDLE;
            m_presc = 0;
        end else begin
            pen_ok = penalty && (st_old == M_RUN || st_old == M_PAUSED);
            if (st_old == M_RUN && !(pause && !pen_ok)) begin
                if (m_presc == TD - 1) begin
                    m_presc = 0; sub = 1; m_tick = 1'b1;
                end else begin
                    m_presc++;
                end
            end
            if (pen_ok) sub += 10;
            if (sub > 0) begin
                m_rem = m_rem - sub;
                if (m_rem <= 0) begin
                    m_rem = 0; m_st = M_EXPIRED;
                end
            end else if (!pen_ok) begin
                if (start && st_old == M_IDLE)        m_st = (m_rem != 0) ? M_RUN : M_EXPIRED;
                else if (start && st_old == M_PAUSED) m_st = M_RUN;
                else if (pause && st_old == M_RUN)    m_st = M_PAUSED;
            end
        end
    end

    always @(negedge clk) begin
        if (check_en) begin
            chk("model_d3", int'(digit_three), m_rem / 100);
            chk("model_d2", int'(digit_two), (m_rem / 10) % 10);
            chk("model_d1", int'(digit_one), m_rem % 10);
            chk("model_running", int'(running), int'(m_st == M_RUN));
            chk("model_expired", int'(expired), int'(m_st == M_EXPIRED));
            chk("model_tick", int'(tick), int'(m_tick));
            chk("model_warning", int'(warning),
                int'((m_st == M_RUN || m_st == M_PAUSED) && m_rem >= 1 && m_rem <= WL));
        end
    end

    task automatic edges(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [3:0] h, input logic [3:0] t, input logic [3:0] u);
        value_three = h; value_two = t; value_one = u; load = 1'b1;
        edges(1);
        load = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1; edges(1); start = 1'b0;
    endtask

    task automatic do_pause();
        pause = 1'b1; edges(1); pause = 1'b0;
    endtask

    task automatic do_penalty();
        penalty = 1'b1; edges(1); penalty = 1'b0;
    endtask

    task automatic lit_digits(input string name, input int h, input int t, input int u);
        chk(name, int'(digit_three) * 100 + int'(digit_two) * 10 + int'(digit_one),
            h * 100 + t * 10 + u);
    endtask

    initial begin
        edges(2);
        reset    = 1'b0;
        check_en = 1'b1;
        lit_digits("reset_digits", 0, 0, 0);
        chk("reset_running", int'(running), 0);
        chk("reset_expired", int'(expired), 0);
        $display("reset released: digits=%0d%0d%0d", digit_three, digit_two, digit_one);

        // 300 counts to 299 after four RUN cycles
        do_load(4'd3, 4'd0, 4'd0);
        do_start();
        edges(3);
        lit_digits("t1_hold", 3, 0, 0);
        edges(1);
        lit_digits("t1_dec", 2, 9, 9);
        chk("t1_tick", int'(tick), 1);
        chk("t1_running", int'(running), 1);
        chk("t1_expired", int'(expired), 0);
        edges(1);
        chk("t1_tick_off", int'(tick), 0);
        $display("t1 300->299: digits=%0d%0d%0d", digit_three, digit_two, digit_one);

        // 002 runs out and stays expired
        do_load(4'd0, 4'd0, 4'd2);
        do_start();
        edges(4);
        lit_digits("t2_first", 0, 0, 1);
        edges(4);
        lit_digits("t2_zero", 0, 0, 0);
        chk("t2_expired", int'(expired), 1);
        do_start();
        chk("t2_sticky", int'(expired), 1);
        $display("t2 002->000: expired=%0d", expired);

        // pause holds time and prescaler phase
        do_load(4'd0, 4'd1, 4'd0);
        do_start();
        edges(2);
        do_pause();
        edges(10);
        lit_digits("t3_paused", 0, 1, 0);
        chk("t3_running", int'(running), 0);
        chk("t3_warn_paused", int'(warning), 1);
        do_start();
        edges(1);
        lit_digits("t3_resume_hold", 0, 1, 0);
        edges(1);
        lit_digits("t3_resume_dec", 0, 0, 9);
        chk("t3_warn", int'(warning), 1);
        $display("t3 pause/resume: digits=%0d%0d%0d", digit_three, digit_two, digit_one);

        // penalties, alone and coincident with a decrement
        do_load(4'd1, 4'd0, 4'd5);
        do_start();
        edges(1);
        do_penalty();
        lit_digits("t4_pen", 0, 9, 5);
        edges(1);
        do_penalty();
        lit_digits("t4_pen_dec", 0, 8, 4);
        chk("t4_tick", int'(tick), 1);
        do_load(4'd0, 4'd0, 4'd7);
        do_start();
        do_penalty();
        lit_digits("t4_sat", 0, 0, 0);
        chk("t4_expired", int'(expired), 1);
        $display("t4 penalty: expired=%0d", expired);

        // penalty ignored in IDLE; clamping; start on zero
        do_load(4'd0, 4'd5, 4'd0);
        do_penalty();
        lit_digits("t5_idle_pen", 0, 5, 0);
        do_load(4'd0, 4'b1100, 4'd15);
        chk("t5_clamp_two", int'(digit_two), 9);
        chk("t5_clamp_one", int'(digit_one), 9);
        do_load(4'd0, 4'd0, 4'd0);
        do_start();
        chk("t5_zero_start", int'(expired), 1);
        $display("t5 clamp/zero: expired=%0d", expired);

        // reset mid-RUN then a normal restart
        do_load(4'd2, 4'd2, 4'd1);
        do_start();
        edges(4);
        lit_digits("t6_pre", 2, 2, 0);
        reset = 1'b1;
        edges(1);
        reset = 1'b0;
        lit_digits("t6_reset", 0, 0, 0);
        chk("t6_running", int'(running), 0);
        chk("t6_warning", int'(warning), 0);
        do_load(4'd2, 4'd4, 4'd0);
        do_start();
        edges(4);
        lit_digits("t6_restart", 2, 3, 9);
        chk("t6_tick", int'(tick), 1);
        $display("t6 reset/restart: digits=%0d%0d%0d", digit_three, digit_two, digit_one);

        edges(2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
